// File: rtl/seq_step_sched.sv
// Round-robin scheduler for two requesters sharing one six-code step sequencer.
// Issues single-cycle step pulses until the granted requester's target code is reached.
module seq_step_sched #(
  parameter int MAX_STEPS = 7
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [1:0] req,
  input  logic [2:0] tgt0,
  input  logic [2:0] tgt1,
  input  logic [2:0] seq_q,
  output logic       step,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       err,
  output logic       busy
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_STEPS);

  typedef enum logic [1:0] {IDLE, CHECK, STEP, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] gnt_q, gnt_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       prio, prio_nxt;
  logic       err_q, err_nxt;
  logic [2:0] tgt;
  logic       tgt_bad;
  logic       req_held;

  // Target follows the granted requester live, so a mid-grant change retargets.
  assign tgt      = gnt_q[1] ? tgt1 : tgt0;
  assign tgt_bad  = (tgt == 3'b100) || (tgt == 3'b110);
  assign req_held = |(req & gnt_q);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      gnt_q <= 2'b00;
      cnt   <= 3'd0;
      prio  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
      cnt   <= cnt_nxt;
      prio  <= prio_nxt;
      err_q <= err_nxt;
    end
  end

  // prio set means requester 1 wins a tie; it only moves on a completed grant.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    cnt_nxt   = cnt;
    prio_nxt  = prio;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = CHECK;
          cnt_nxt   = 3'd0;
          err_nxt   = 1'b0;
          gnt_nxt   = (req == 2'b11) ? (prio ? 2'b10 : 2'b01) : req;
        end
      end
      CHECK: begin
        if (!req_held) begin
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
        end else if (tgt_bad) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (seq_q == tgt) begin
          state_nxt = DONE;
          err_nxt   = 1'b0;
        end else if (cnt == MAX_CNT) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = STEP;
        end
      end
      STEP: begin
        state_nxt = CHECK;
        cnt_nxt   = cnt + 3'd1;
      end
      DONE: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
        prio_nxt  = gnt_q[0];
        err_nxt   = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  assign step = (state == STEP);
  assign busy = (state != IDLE);
  assign gnt  = gnt_q;
  assign done = (state == DONE) ? gnt_q : 2'b00;
  assign err  = (state == DONE) && err_q;

endmodule

// File: tb/tb_seq_step_sched.sv
// Scoreboard bench for seq_step_sched: two instances (default limit and limit 2),
// each driving its own behavioural six-code sequencer.
module tb_seq_step_sched;

  typedef struct {
    logic [1:0] done;
    logic       err;
    int         cyc;
    int         steps;
  } exp_t;

  logic       clk;
  logic       n_reset;
  logic [1:0] req_v  [2];
  logic [2:0] t0_v   [2];
  logic [2:0] t1_v   [2];
  logic [2:0] seq_v  [2];
  logic       step_v [2];
  logic [1:0] gnt_v  [2];
  logic [1:0] done_v [2];
  logic       err_v  [2];
  logic       busy_v [2];
  logic       seq_load [2];
  logic [2:0] seq_init [2];

  int   cyc;
  int   start;
  int   n_checks;
  int   n_pass;
  exp_t qa[$];
  exp_t qb[$];

  int         step_total [2];
  int         step_base  [2];
  logic       prev_step  [2];
  logic [1:0] prev_gnt   [2];
  logic [1:0] prev_done  [2];

  seq_step_sched dut_a (
    .clk(clk), .n_reset(n_reset), .req(req_v[0]), .tgt0(t0_v[0]), .tgt1(t1_v[0]),
    .seq_q(seq_v[0]), .step(step_v[0]), .gnt(gnt_v[0]), .done(done_v[0]),
    .err(err_v[0]), .busy(busy_v[0])
  );

  seq_step_sched #(.MAX_STEPS(2)) dut_b (
    .clk(clk), .n_reset(n_reset), .req(req_v[1]), .tgt0(t0_v[1]), .tgt1(t1_v[1]),
    .seq_q(seq_v[1]), .step(step_v[1]), .gnt(gnt_v[1]), .done(done_v[1]),
    .err(err_v[1]), .busy(busy_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] seqNext(input logic [2:0] s);
    case (s)
      3'b000:  return 3'b001;
      3'b001:  return 3'b011;
      3'b011:  return 3'b101;
      3'b101:  return 3'b111;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Sequencer model: one cycle of latency, independent of the scheduler reset.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (seq_load[i]) seq_v[i] <= seq_init[i];
      else if (step_v[i]) seq_v[i] <= seqNext(seq_v[i]);
    end
  end

  task automatic checkOutput(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want)
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    else
      n_pass++;
  endtask

  task automatic applyStimulus(input int d, input logic [1:0] r,
                               input logic [2:0] a, input logic [2:0] b);
    req_v[d] = r;
    t0_v[d]  = a;
    t1_v[d]  = b;
    start    = cyc;
  endtask

  task automatic expectDone(input int d, input logic [1:0] dn, input logic er,
                            input int n, input int st);
    exp_t e;
    e.done  = dn;
    e.err   = er;
    e.cyc   = start + n;
    e.steps = st;
    if (d == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic setSeq(input int d, input logic [2:0] v);
    seq_load[d] = 1'b1;
    seq_init[d] = v;
    @(negedge clk);
    seq_load[d] = 1'b0;
  endtask

  task automatic atCycle(input int n);
    while (cyc < start + n) @(negedge clk);
  endtask

  // Monitor: step spacing, grant release after done, and done/err against the queue.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (gnt_v[i] != 2'b00 && prev_gnt[i] == 2'b00) step_base[i] = step_total[i];
      if (step_v[i]) begin
        checkOutput("step_gap", int'(prev_step[i]), 0);
        step_total[i]++;
      end
      if (prev_done[i] != 2'b00) begin
        checkOutput("gnt_drop", int'(gnt_v[i]), 0);
        checkOutput("busy_drop", int'(busy_v[i]), 0);
      end
      if (done_v[i] != 2'b00) begin
        if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
          checkOutput("unexpected_done", int'(done_v[i]), 0);
        end else begin
          if (i == 0) e = qa.pop_front();
          else e = qb.pop_front();
          checkOutput("done_val", int'(done_v[i]), int'(e.done));
          checkOutput("err_val", int'(err_v[i]), int'(e.err));
          checkOutput("done_cycle", cyc, e.cyc);
          checkOutput("step_count", step_total[i] - step_base[i], e.steps);
          checkOutput("gnt_at_done", int'(gnt_v[i]), int'(e.done));
        end
      end
      prev_step[i] = step_v[i];
      prev_gnt[i]  = gnt_v[i];
      prev_done[i] = done_v[i];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    cyc      = 0;
    start    = 0;
    n_checks = 0;
    n_pass   = 0;
    n_reset  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 2'b00; t0_v[i] = 3'b000; t1_v[i] = 3'b000;
      seq_load[i] = 1'b1; seq_init[i] = 3'b000;
      step_total[i] = 0; step_base[i] = 0;
      prev_step[i] = 1'b0; prev_gnt[i] = 2'b00; prev_done[i] = 2'b00;
    end
    repeat (2) @(negedge clk);
    seq_load[0] = 1'b0;
    seq_load[1] = 1'b0;
    checkOutput("rst_step", int'(step_v[0]), 0);
    checkOutput("rst_gnt", int'(gnt_v[0]), 0);
    checkOutput("rst_done", int'(done_v[0]), 0);
    checkOutput("rst_err", int'(err_v[0]), 0);
    checkOutput("rst_busy", int'(busy_v[0]), 0);
    n_reset = 1'b1;
    @(negedge clk);

    // Four steps from 000 to 111.
    setSeq(0, 3'b000);
    applyStimulus(0, 2'b01, 3'b111, 3'b000);
    expectDone(0, 2'b01, 1'b0, 10, 4);
    atCycle(1);
    checkOutput("first_gnt", int'(gnt_v[0]), 1);
    checkOutput("first_busy", int'(busy_v[0]), 1);
    atCycle(10);
    req_v[0] = 2'b00;
    atCycle(12);

    // Asynchronous reset while a step pulse is high.
    setSeq(0, 3'b000);
    applyStimulus(0, 2'b01, 3'b111, 3'b000);
    atCycle(2);
    checkOutput("pre_rst_step", int'(step_v[0]), 1);
    #2 n_reset = 1'b0;
    #1;
    checkOutput("async_rst_step", int'(step_v[0]), 0);
    checkOutput("async_rst_gnt", int'(gnt_v[0]), 0);
    checkOutput("async_rst_busy", int'(busy_v[0]), 0);
    @(negedge clk);
    req_v[0] = 2'b00;
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    // Both requesting after reset: requester 0 first, then requester 1 with one step.
    setSeq(0, 3'b010);
    applyStimulus(0, 2'b11, 3'b010, 3'b000);
    expectDone(0, 2'b01, 1'b0, 2, 0);
    expectDone(0, 2'b10, 1'b0, 7, 1);
    atCycle(1);
    checkOutput("tie_gnt", int'(gnt_v[0]), 1);
    atCycle(2);
    req_v[0] = 2'b10;
    atCycle(4);
    checkOutput("second_gnt", int'(gnt_v[0]), 2);
    atCycle(7);
    req_v[0] = 2'b00;
    atCycle(9);

    // Invalid target.
    setSeq(0, 3'b000);
    applyStimulus(0, 2'b10, 3'b000, 3'b100);
    expectDone(0, 2'b10, 1'b1, 2, 0);
    atCycle(2);
    req_v[0] = 2'b00;
    atCycle(3);

    // Completed grant for requester 0, then an aborted one.
    setSeq(0, 3'b000);
    applyStimulus(0, 2'b01, 3'b000, 3'b000);
    expectDone(0, 2'b01, 1'b0, 2, 0);
    atCycle(2);
    req_v[0] = 2'b00;
    atCycle(3);
    applyStimulus(0, 2'b01, 3'b111, 3'b000);
    base = step_total[0];
    atCycle(4);
    checkOutput("abort_step2", int'(step_v[0]), 1);
    req_v[0] = 2'b00;
    atCycle(5);
    checkOutput("abort_check_gnt", int'(gnt_v[0]), 1);
    atCycle(6);
    checkOutput("abort_gnt", int'(gnt_v[0]), 0);
    checkOutput("abort_busy", int'(busy_v[0]), 0);
    checkOutput("abort_steps", step_total[0] - base, 2);
    applyStimulus(0, 2'b11, 3'b000, 3'b011);
    expectDone(0, 2'b10, 1'b0, 2, 0);
    atCycle(1);
    checkOutput("rr_after_abort", int'(gnt_v[0]), 2);
    atCycle(2);
    req_v[0] = 2'b00;
    atCycle(4);

    // Step limit of 2 starting from a non-sequence code.
    setSeq(1, 3'b110);
    applyStimulus(1, 2'b01, 3'b101, 3'b000);
    expectDone(1, 2'b01, 1'b1, 6, 2);
    atCycle(6);
    req_v[1] = 2'b00;
    atCycle(9);

    checkOutput("pending_a", qa.size(), 0);
    checkOutput("pending_b", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
